// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment display blocks.
//
// Contents:
//   MAX_DIGITS        widest digit bank any display block supports
//   DEFAULT_N_DIGITS  digit count used when a block is not parameterised
//   nibble_t          one hex digit, as consumed by the display7 decoder
//   ANODO_OFF(width)  all-ones anode pattern (every digit dark) of the given width
package display_pkg;

    localparam int MAX_DIGITS       = 8;
    localparam int DEFAULT_N_DIGITS = 4;

    typedef logic [3:0] nibble_t;

    // Anodes are active-low, so "all off" is all ones. The result is sized
    // for the widest bank; callers cast it down to their own width.
    function automatic logic [MAX_DIGITS-1:0] ANODO_OFF(input int width);
        logic [MAX_DIGITS-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < width) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// Refresh prescaler for multiplexed displays.
//
// Counts 0..DIV-1 and raises tick_o for the single cycle on which the count
// is DIV-1, then wraps. The first tick arrives DIV cycles after reset is
// released.
//
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   tick_o  one-cycle slot-advance pulse
module refresh_tick_gen #(
    parameter int DIV = 27000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int             CW   = $clog2(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick_o = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick_o) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
//
// Each slot presents one nibble for the downstream display7 decoder and drives
// the matching active-low anode. A loaded value waits in a pending register and
// only reaches the displayed (shadow) value at a frame boundary, so a frame is
// never drawn from two different values. Optional leading-zero blanking.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   valor_i     packed hex digits, digit 0 in bits [3:0]
//   load_i      one-cycle strobe capturing valor_i
//   blank_lz_i  1 = suppress leading zeros
//   palabra_o   nibble to the display7 decoder
//   anodo_o     active-low digit enables, one-hot-low or all ones
//   frame_o     one-cycle pulse when the scan wraps
module display_scan
    import display_pkg::*;
#(
    parameter int N_DIGITS    = DEFAULT_N_DIGITS,
    parameter int REFRESH_DIV = 27000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] valor_i,
    input  logic                  load_i,
    input  logic                  blank_lz_i,
    output nibble_t               palabra_o,
    output logic [N_DIGITS-1:0]   anodo_o,
    output logic                  frame_o
);

    localparam int                    IW       = $clog2(N_DIGITS);
    localparam logic [IW-1:0]         LAST_IDX = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0]   OFF      = N_DIGITS'(ANODO_OFF(N_DIGITS));

    logic                  tick;
    logic                  boundary;
    logic                  post_tick;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         nxt;
    logic [4*N_DIGITS-1:0] pending;
    logic [4*N_DIGITS-1:0] shadow;
    logic [4*N_DIGITS-1:0] shadow_eff;
    logic                  pend_flag;
    logic [N_DIGITS-1:0]   blank;
    logic [N_DIGITS-1:0]   lit;

    refresh_tick_gen #(
        .DIV (REFRESH_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    // Slot sequencing. On a boundary tick the nibble for digit 0 must come
    // from the value being promoted this cycle, not the old shadow.
    always_comb begin
        boundary   = tick && (idx == LAST_IDX);
        nxt        = (idx == LAST_IDX) ? '0 : idx + IW'(1);
        shadow_eff = (boundary && pend_flag) ? pending : shadow;
    end

    // Digit k > 0 is blanked when it and every digit above it are zero;
    // scanning from the top keeps a running "all zero so far" flag.
    // Digit 0 always lights.
    always_comb begin
        logic zero_above;
        blank      = '0;
        zero_above = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (shadow[4*k +: 4] == 4'h0);
            blank[k]   = blank_lz_i && zero_above;
        end
        lit = blank[idx] ? OFF : ~(N_DIGITS'(1) << idx);
    end

    // Register state and outputs. A tick blanks all anodes for one cycle
    // (ghosting dead time) while the new nibble settles; the anode for the
    // new slot is enabled on the following cycle and held until the next tick.
    // A load on the boundary tick lands in pending after the old pending
    // value has been promoted, so it shows one frame later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            pending   <= '0;
            pend_flag <= 1'b0;
            shadow    <= '0;
            post_tick <= 1'b0;
            palabra_o <= '0;
            anodo_o   <= OFF;
            frame_o   <= 1'b0;
        end else begin
            post_tick <= tick;
            frame_o   <= boundary;

            if (boundary && pend_flag) begin
                shadow <= pending;
            end

            if (load_i) begin
                pending   <= valor_i;
                pend_flag <= 1'b1;
            end else if (boundary) begin
                pend_flag <= 1'b0;
            end

            if (tick) begin
                idx       <= nxt;
                anodo_o   <= OFF;
                palabra_o <= shadow_eff[{nxt, 2'b00} +: 4];
            end else if (post_tick) begin
                anodo_o <= lit;
            end
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan (4 digits, 4 clocks per slot).
//
// A stimulus process drives inputs just after each rising edge; on the next
// rising edge a frame-level reference model works out what the display should
// show after that edge and queues it. A monitor pops one expectation every
// falling edge and compares it with the DUT outputs.
module tb_display_scan;

    localparam int ND    = 4;
    localparam int DIV   = 4;
    localparam int FRAME = ND * DIV;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic [15:0] valor_i    = '0;
    logic        load_i     = 1'b0;
    logic        blank_lz_i = 1'b0;
    logic [3:0]  palabra_o;
    logic [3:0]  anodo_o;
    logic        frame_o;

    display_scan #(
        .N_DIGITS    (ND),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valor_i    (valor_i),
        .load_i     (load_i),
        .blank_lz_i (blank_lz_i),
        .palabra_o  (palabra_o),
        .anodo_o    (anodo_o),
        .frame_o    (frame_o)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] anodo;
        logic [3:0] palabra;
        logic       frame;
    } expect_t;

    expect_t     sb_q[$];
    int          errors = 0;
    int          checks = 0;

    // Reference model state: edges since reset release, value on screen,
    // loads received since the last frame boundary, digit of current slot,
    // and what the outputs should be holding.
    int          edge_count = 0;
    logic [15:0] shown      = '0;
    logic [15:0] loads_q[$];
    int          cur_digit  = 0;
    expect_t     held       = '{anodo: 4'hF, palabra: 4'h0, frame: 1'b0};

    function automatic logic [3:0] digit_of(input logic [15:0] v, input int k);
        return 4'((v >> (4 * k)) & 16'hF);
    endfunction

    function automatic bit is_blank(input logic [15:0] v, input int k, input logic blz);
        return blz && (k > 0) && ((v >> (4 * k)) == 16'h0);
    endfunction

    // Frame-level model, evaluated right at a rising edge with the inputs
    // that were presented for that edge. A frame shows the last value loaded
    // before its boundary edge; slot m shows digit m mod 4 after one dark cycle.
    function automatic void modelEdge();
        if (!rst_n) begin
            edge_count = 0;
            shown      = '0;
            loads_q.delete();
            cur_digit  = 0;
            held       = '{anodo: 4'hF, palabra: 4'h0, frame: 1'b0};
        end else begin
            edge_count++;
            held.frame = 1'b0;
            if (edge_count % DIV == 0) begin
                if (edge_count % FRAME == 0) begin
                    if (loads_q.size() > 0) begin
                        shown = loads_q[$];
                    end
                    loads_q.delete();
                    held.frame = 1'b1;
                end
                cur_digit    = (edge_count / DIV) % ND;
                held.anodo   = 4'hF;
                held.palabra = digit_of(shown, cur_digit);
            end else if ((edge_count % DIV == 1) && (edge_count > DIV)) begin
                held.anodo = is_blank(shown, cur_digit, blank_lz_i) ? 4'hF
                                                                    : ~(4'(1) << cur_digit);
            end
            if (load_i) begin
                loads_q.push_back(valor_i);
            end
        end
        sb_q.push_back(held);
    endfunction

    // Compare the DUT outputs against one expectation.
    task automatic checkOutput(input string name, input expect_t e);
        checks++;
        if (anodo_o !== e.anodo || palabra_o !== e.palabra || frame_o !== e.frame) begin
            errors++;
            $display("[TB] FAIL %s @%0t: anodo=%b palabra=%h frame=%b, expected anodo=%b palabra=%h frame=%b",
                     name, $time, anodo_o, palabra_o, frame_o, e.anodo, e.palabra, e.frame);
        end
    endtask

    // Drive one cycle of inputs, let the model see the edge, then step off it.
    task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic blz);
        load_i     = ld;
        valor_i    = v;
        blank_lz_i = blz;
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic idle(input int n, input logic blz);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 16'h0000, blz);
        end
    endtask

    // Monitor: one expectation per falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            checkOutput("scan", sb_q.pop_front());
        end
    end

    initial begin
        logic        ld;
        logic [15:0] v;
        logic        blz;
        int          n;

        $display("[TB] display_scan bench start");

        // Held in reset, then released just after an edge.
        idle(3, 1'b0);
        checkOutput("reset_hold", '{anodo: 4'hF, palabra: 4'h0, frame: 1'b0});
        rst_n = 1'b1;

        // Zero value: anodes rotate starting at digit 1, palabra stays 0.
        idle(40, 1'b0);

        // Mid-frame load appears only after the next boundary.
        applyStimulus(1'b1, 16'h12AF, 1'b0);
        idle(48, 1'b0);

        // Leading-zero blanking with 0030, then with 0.
        applyStimulus(1'b1, 16'h0030, 1'b1);
        idle(48, 1'b1);
        applyStimulus(1'b1, 16'h0000, 1'b1);
        idle(48, 1'b1);

        // Back-to-back loads: the last one wins.
        applyStimulus(1'b1, 16'h1111, 1'b0);
        applyStimulus(1'b1, 16'h2222, 1'b0);
        idle(40, 1'b0);

        // Load coinciding with the boundary tick shows a frame later.
        while ((edge_count + 1) % FRAME != 0) begin
            applyStimulus(1'b0, 16'h0000, 1'b0);
        end
        applyStimulus(1'b1, 16'h4567, 1'b0);
        idle(40, 1'b0);

        // Randomised loads, values with random leading zeros, blanking toggles.
        blz = 1'b0;
        repeat (800) begin
            ld = ($urandom_range(0, 7) == 0);
            v  = 16'($urandom);
            n  = $urandom_range(0, 4);
            if (n < 4) begin
                v = v & 16'((32'h1 << (4 * n)) - 1);
            end
            if ($urandom_range(0, 31) == 0) begin
                blz = ~blz;
            end
            applyStimulus(ld, v, blz);
        end

        // Reset mid-frame during slot 2 with a load still pending.
        applyStimulus(1'b1, 16'h9876, 1'b0);
        idle(2 * FRAME, 1'b0);
        while (!(cur_digit == 2 && edge_count % DIV == 1)) begin
            applyStimulus(1'b0, 16'h0000, 1'b0);
        end
        applyStimulus(1'b1, 16'hBEEF, 1'b0);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        checkOutput("reset_async", '{anodo: 4'hF, palabra: 4'h0, frame: 1'b0});
        idle(2, 1'b0);
        rst_n = 1'b1;
        idle(40, 1'b0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
